// File: rtl/writeback_stage.sv
// writeback_stage
// Final pipeline stage. It accepts completed instructions from the memory
// stage and drives the register-file and predicate write ports. Non-load
// results retire one cycle after acceptance. Loads are parked in WAIT_LOAD
// until the memory response arrives or MAX_WAIT cycles elapse. A timed-out
// load is dropped without a writeback and raises a sticky flag.
//
// Ports:
//   clk, n_rst                 clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake (ready only in IDLE)
//   in_reg_write, in_reg_addr  destination register control
//   in_alu_data                result for non-load instructions
//   in_is_load                 result comes from the memory response
//   in_ps_write, in_ps_data    predicate register write
//   mem_resp_valid/_data       variable-latency load response
//   writeback_valid            one-cycle retire pulse
//   reg_write/reg_addr/reg_data, ps_write/ps_data   register-file write port
//   pending_valid/pending_addr outstanding load destination (hazard check)
//   load_timeout               sticky: a load was abandoned
//   retired_count              number of retire pulses, wraps at 2^16
module writeback_stage #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int MAX_WAIT = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_reg_addr,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic              in_is_load,
    input  logic              in_ps_write,
    input  logic              in_ps_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              writeback_valid,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic              ps_write,
    output logic              ps_data,
    output logic              pending_valid,
    output logic [ADDR_W-1:0] pending_addr,
    output logic              load_timeout,
    output logic [15:0]       retired_count
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  wait_cnt;
    logic              ld_reg_write;
    logic [ADDR_W-1:0] ld_reg_addr;
    logic              ld_ps_write;
    logic              ld_ps_data;
    logic              accept;
    logic              timed_out;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // A response on the last allowed cycle takes priority over the timeout.
    assign timed_out = (state == WAIT_LOAD) && !mem_resp_valid &&
                       (wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && in_is_load) begin
                    state_next = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (mem_resp_valid || timed_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: retire pulses, load control latch, wait counter and status.
    // Write-port fields hold their last value between retires; they are only
    // meaningful while writeback_valid is high.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            writeback_valid <= 1'b0;
            reg_write       <= 1'b0;
            reg_addr        <= '0;
            reg_data        <= '0;
            ps_write        <= 1'b0;
            ps_data         <= 1'b0;
            pending_valid   <= 1'b0;
            pending_addr    <= '0;
            load_timeout    <= 1'b0;
            retired_count   <= '0;
            wait_cnt        <= '0;
            ld_reg_write    <= 1'b0;
            ld_reg_addr     <= '0;
            ld_ps_write     <= 1'b0;
            ld_ps_data      <= 1'b0;
        end else begin
            writeback_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_is_load) begin
                            ld_reg_write  <= in_reg_write;
                            ld_reg_addr   <= in_reg_addr;
                            ld_ps_write   <= in_ps_write;
                            ld_ps_data    <= in_ps_data;
                            wait_cnt      <= '0;
                            pending_valid <= in_reg_write;
                            pending_addr  <= in_reg_addr;
                        end else begin
                            writeback_valid <= 1'b1;
                            reg_write       <= in_reg_write;
                            reg_addr        <= in_reg_addr;
                            reg_data        <= in_alu_data;
                            ps_write        <= in_ps_write;
                            ps_data         <= in_ps_data;
                            retired_count   <= retired_count + 16'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_resp_valid) begin
                        writeback_valid <= 1'b1;
                        reg_write       <= ld_reg_write;
                        reg_addr        <= ld_reg_addr;
                        reg_data        <= mem_resp_data;
                        ps_write        <= ld_ps_write;
                        ps_data         <= ld_ps_data;
                        retired_count   <= retired_count + 16'd1;
                        pending_valid   <= 1'b0;
                    end else if (timed_out) begin
                        load_timeout  <= 1'b1;
                        pending_valid <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
// Self-checking bench for writeback_stage. Non-load vectors come from a
// table; loads, timeouts and reset are hand-written sequences. Every
// expected retire is pushed to a scoreboard queue together with the cycle
// in which it must appear, and a negedge monitor pops and compares it.
module tb_writeback_stage;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int MAX_WAIT = 32;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic [ADDR_W-1:0] in_reg_addr;
    logic [DATA_W-1:0] in_alu_data;
    logic              in_is_load;
    logic              in_ps_write;
    logic              in_ps_data;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              writeback_valid;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_data;
    logic              ps_write;
    logic              ps_data;
    logic              pending_valid;
    logic [ADDR_W-1:0] pending_addr;
    logic              load_timeout;
    logic [15:0]       retired_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              psw;
        logic              psd;
        int                cyc;
    } sb_t;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              psw;
        logic              psd;
        logic              exp_rw;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        logic              exp_psw;
        logic              exp_psd;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];

    writeback_stage #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_reg_write   (in_reg_write),
        .in_reg_addr    (in_reg_addr),
        .in_alu_data    (in_alu_data),
        .in_is_load     (in_is_load),
        .in_ps_write    (in_ps_write),
        .in_ps_data     (in_ps_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .writeback_valid(writeback_valid),
        .reg_write      (reg_write),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .ps_write       (ps_write),
        .ps_data        (ps_data),
        .pending_valid  (pending_valid),
        .pending_addr   (pending_addr),
        .load_timeout   (load_timeout),
        .retired_count  (retired_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic rw,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data,
                                 input logic ld, input logic psw,
                                 input logic psd);
        in_valid     = v;
        in_reg_write = rw;
        in_reg_addr  = addr;
        in_alu_data  = data;
        in_is_load   = ld;
        in_ps_write  = psw;
        in_ps_data   = psd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The retire must appear in the cycle right after the next active edge.
    task automatic expectRetire(input logic rw, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data,
                                input logic psw, input logic psd);
        sb.push_back('{rw, addr, data, psw, psd, cyc + 1});
    endtask

    task automatic doReset();
        n_rst = 1'b0;
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        step();
        step();
        n_rst = 1'b1;
    endtask

    // Scoreboard monitor: every retire pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (n_rst === 1'b1 && writeback_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("wb_unexpected", {31'b0, writeback_valid}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                checkOutput("wb_cycle", cyc, e.cyc);
                checkOutput("wb_reg_write", {31'b0, reg_write}, {31'b0, e.rw});
                checkOutput("wb_reg_addr", {28'b0, reg_addr}, {28'b0, e.addr});
                checkOutput("wb_reg_data", {16'b0, reg_data}, {16'b0, e.data});
                checkOutput("wb_ps_write", {31'b0, ps_write}, {31'b0, e.psw});
                checkOutput("wb_ps_data", {31'b0, ps_data}, {31'b0, e.psd});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 4'h1, 16'h1111, 0, 0, 1, 4'h1, 16'h1111, 0, 0};
        vecs[1] = '{1, 4'h2, 16'h2222, 0, 0, 1, 4'h2, 16'h2222, 0, 0};
        vecs[2] = '{1, 4'h3, 16'h3333, 0, 0, 1, 4'h3, 16'h3333, 0, 0};
        vecs[3] = '{0, 4'h4, 16'h4444, 1, 1, 0, 4'h4, 16'h4444, 1, 1};
        vecs[4] = '{0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 16'h0000, 0, 0};
        vecs[5] = '{1, 4'hF, 16'hFFFF, 1, 0, 1, 4'hF, 16'hFFFF, 1, 0};

        // Reset state.
        doReset();
        checkOutput("rst_wb_valid", {31'b0, writeback_valid}, 0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 1);
        checkOutput("rst_pending", {31'b0, pending_valid}, 0);
        checkOutput("rst_timeout", {31'b0, load_timeout}, 0);
        checkOutput("rst_retired", {16'b0, retired_count}, 0);
        checkOutput("rst_reg_data", {16'b0, reg_data}, 0);

        // Back-to-back non-loads from the table.
        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].rw, vecs[i].addr, vecs[i].data, 0,
                          vecs[i].psw, vecs[i].psd);
            expectRetire(vecs[i].exp_rw, vecs[i].exp_addr, vecs[i].exp_data,
                         vecs[i].exp_psw, vecs[i].exp_psd);
            step();
            checkOutput("tbl_wb_valid", {31'b0, writeback_valid}, 1);
            if (i == 2) checkOutput("tbl_retired3", {16'b0, retired_count}, 3);
        end
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        checkOutput("tbl_retired6", {16'b0, retired_count}, 6);
        step();
        checkOutput("tbl_idle_wb", {31'b0, writeback_valid}, 0);

        // Load to r5, response 4 cycles after accept; upstream keeps
        // presenting a changing instruction while the load is held.
        applyStimulus(1, 1, 4'h5, 16'hDEAD, 1, 0, 0);
        step();
        applyStimulus(1, 1, 4'h9, 16'h9999, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ld_in_ready", {31'b0, in_ready}, 0);
            checkOutput("ld_pending", {31'b0, pending_valid}, 1);
            checkOutput("ld_pending_addr", {28'b0, pending_addr}, 5);
            if (i == 2) applyStimulus(1, 1, 4'h7, 16'h7777, 0, 1, 1);
            if (i == 3) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 16'hBEEF;
                expectRetire(1, 4'h5, 16'hBEEF, 0, 0);
            end
            step();
        end
        mem_resp_valid = 1'b0;
        checkOutput("ld_ready_back", {31'b0, in_ready}, 1);
        checkOutput("ld_pending_clr", {31'b0, pending_valid}, 0);
        expectRetire(1, 4'h7, 16'h7777, 1, 1);
        step();
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        step();
        checkOutput("ld_retired", {16'b0, retired_count}, 8);

        // Load with no response: abandoned after MAX_WAIT cycles.
        applyStimulus(1, 1, 4'hA, 16'h0, 1, 0, 0);
        step();
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        for (int i = 0; i < MAX_WAIT; i++) begin
            checkOutput("to_in_ready", {31'b0, in_ready}, 0);
            checkOutput("to_flag_early", {31'b0, load_timeout}, 0);
            step();
        end
        checkOutput("to_ready_back", {31'b0, in_ready}, 1);
        checkOutput("to_flag", {31'b0, load_timeout}, 1);
        checkOutput("to_pending_clr", {31'b0, pending_valid}, 0);
        checkOutput("to_no_wb", {31'b0, writeback_valid}, 0);
        applyStimulus(1, 1, 4'hB, 16'hB0B0, 0, 0, 0);
        expectRetire(1, 4'hB, 16'hB0B0, 0, 0);
        step();
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        step();
        checkOutput("to_flag_sticky", {31'b0, load_timeout}, 1);
        checkOutput("to_retired", {16'b0, retired_count}, 9);

        // Response on the final allowed cycle wins over the timeout.
        doReset();
        applyStimulus(1, 1, 4'h3, 16'h0, 1, 1, 1);
        step();
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        repeat (MAX_WAIT - 1) step();
        checkOutput("late_in_ready", {31'b0, in_ready}, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h5A5A;
        expectRetire(1, 4'h3, 16'h5A5A, 1, 1);
        step();
        mem_resp_valid = 1'b0;
        checkOutput("late_flag", {31'b0, load_timeout}, 0);
        checkOutput("late_ready", {31'b0, in_ready}, 1);
        checkOutput("late_retired", {16'b0, retired_count}, 1);

        // Response while idle is ignored.
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'h1234;
        step();
        mem_resp_valid = 1'b0;
        checkOutput("idle_resp_wb", {31'b0, writeback_valid}, 0);
        checkOutput("idle_resp_flag", {31'b0, load_timeout}, 0);
        checkOutput("idle_resp_retired", {16'b0, retired_count}, 1);

        // Reset in the middle of a load; a later response must not retire.
        applyStimulus(1, 1, 4'h6, 16'h0, 1, 1, 1);
        step();
        applyStimulus(0, 0, '0, '0, 0, 0, 0);
        step();
        step();
        n_rst = 1'b0;
        step();
        n_rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 16'hAAAA;
        step();
        mem_resp_valid = 1'b0;
        step();
        checkOutput("mr_wb_valid", {31'b0, writeback_valid}, 0);
        checkOutput("mr_reg_write", {31'b0, reg_write}, 0);
        checkOutput("mr_reg_addr", {28'b0, reg_addr}, 0);
        checkOutput("mr_reg_data", {16'b0, reg_data}, 0);
        checkOutput("mr_ps", {30'b0, ps_write, ps_data}, 0);
        checkOutput("mr_pending", {31'b0, pending_valid}, 0);
        checkOutput("mr_pending_addr", {28'b0, pending_addr}, 0);
        checkOutput("mr_flag", {31'b0, load_timeout}, 0);
        checkOutput("mr_in_ready", {31'b0, in_ready}, 1);
        checkOutput("mr_retired", {16'b0, retired_count}, 0);

        step();
        checkOutput("sb_leftover", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
